// File: rtl/wb_regfile_if.sv
// Bus between the MEM/WB pipeline register, decode read ports and the write-back regfile.
interface wb_regfile_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 32
);
  logic              WBreg;
  logic              RegWritereg;
  logic [ADDR_W-1:0] RegRDreg;
  logic [DATA_W-1:0] Memreg;
  logic [DATA_W-1:0] ALUreg;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] wb_data;
  logic              wb_commit;
  logic [CNT_W-1:0]  wr_count;

  modport master (
    output WBreg, RegWritereg, RegRDreg, Memreg, ALUreg, rs_addr, rt_addr,
    input  rs_data, rt_data, wb_data, wb_commit, wr_count
  );

  modport slave (
    input  WBreg, RegWritereg, RegRDreg, Memreg, ALUreg, rs_addr, rt_addr,
    output rs_data, rt_data, wb_data, wb_commit, wr_count
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back select plus 2-read/1-write architectural register file with r0 hardwired to zero,
// optional same-cycle write-to-read bypass and a wrapping retired-write counter.
module wb_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned BYPASS = 1,
  parameter int unsigned CNT_W  = 32
) (
  input logic         clock,
  input logic         rst_n,
  wb_regfile_if.slave bus
);
  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [Depth];
  logic              commit_q;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] wb_val;
  logic              we;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;

  assign wb_val = bus.WBreg ? bus.Memreg : bus.ALUreg;

  // Gating with rst_n keeps the bypass path from leaking data while reset is held.
  assign we = bus.RegWritereg && (|bus.RegRDreg) && rst_n;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
      commit_q <= 1'b0;
      count_q  <= '0;
    end else begin
      commit_q <= we;
      if (we) begin
        regs_q[bus.RegRDreg] <= wb_val;
        count_q              <= count_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    rs_val = regs_q[bus.rs_addr];
    if ((BYPASS != 0) && we && (bus.rs_addr == bus.RegRDreg)) begin
      rs_val = wb_val;
    end
    if (!rst_n || (bus.rs_addr == '0)) begin
      rs_val = '0;
    end
  end

  always_comb begin
    rt_val = regs_q[bus.rt_addr];
    if ((BYPASS != 0) && we && (bus.rt_addr == bus.RegRDreg)) begin
      rt_val = wb_val;
    end
    if (!rst_n || (bus.rt_addr == '0)) begin
      rt_val = '0;
    end
  end

  assign bus.wb_data   = wb_val;
  assign bus.rs_data   = rs_val;
  assign bus.rt_data   = rt_val;
  assign bus.wb_commit = commit_q;
  assign bus.wr_count  = count_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: a bypassing 32-bit-counter build and a non-bypassing 4-bit-counter build
// share the same stimulus; expectations are queued and drained by a monitor.
module tb_wb_regfile;
  localparam int SelRsA = 0, SelRtA = 1, SelWbA = 2, SelComA = 3, SelCntA = 4;
  localparam int SelRsB = 5, SelRtB = 6, SelCntB = 7, SelComB = 8;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  logic clock;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  exp_t sb_q[$];
  event chk_ev;

  wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) ifa ();
  wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  ifb ();

  assign ifb.WBreg       = ifa.WBreg;
  assign ifb.RegWritereg = ifa.RegWritereg;
  assign ifb.RegRDreg    = ifa.RegRDreg;
  assign ifb.Memreg      = ifa.Memreg;
  assign ifb.ALUreg      = ifa.ALUreg;
  assign ifb.rs_addr     = ifa.rs_addr;
  assign ifb.rt_addr     = ifa.rt_addr;

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1), .CNT_W(32)) dut_a (
    .clock(clock),
    .rst_n(rst_n),
    .bus  (ifa)
  );

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(0), .CNT_W(4)) dut_b (
    .clock(clock),
    .rst_n(rst_n),
    .bus  (ifb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] obs(int s);
    case (s)
      SelRsA:  return ifa.rs_data;
      SelRtA:  return ifa.rt_data;
      SelWbA:  return ifa.wb_data;
      SelComA: return {31'b0, ifa.wb_commit};
      SelCntA: return ifa.wr_count;
      SelRsB:  return ifb.rs_data;
      SelRtB:  return ifb.rt_data;
      SelCntB: return {28'b0, ifb.wr_count};
      default: return {31'b0, ifb.wb_commit};
    endcase
  endfunction

  // Monitor: drains every queued expectation whenever the stimulus marks a sample point.
  initial begin
    exp_t e;
    logic [31:0] got;
    forever begin
      @(chk_ev);
      while (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        got = obs(e.sel);
        n_tests++;
        if (got !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got %h, expected %h", e.name, got, e.exp);
        end
      end
    end
  end

  task automatic expect_val(input string name, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  task automatic sample();
    -> chk_ev;
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] rd, input logic sel,
                       input logic [31:0] mem, input logic [31:0] alu);
    ifa.RegWritereg = we;
    ifa.RegRDreg    = rd;
    ifa.WBreg       = sel;
    ifa.Memreg      = mem;
    ifa.ALUreg      = alu;
  endtask

  task automatic wr(input logic [4:0] rd, input logic sel, input logic [31:0] mem,
                    input logic [31:0] alu);
    drive(1'b1, rd, sel, mem, alu);
    @(posedge clock);
    #1;
  endtask

  task automatic rd_ports(input logic [4:0] a, input logic [4:0] b);
    ifa.RegWritereg = 1'b0;
    ifa.rs_addr     = a;
    ifa.rt_addr     = b;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    ifa.rs_addr = 5'd0;
    ifa.rt_addr = 5'd0;
    #2;
    expect_val("reset_rs", SelRsA, 32'h0);
    expect_val("reset_cnt", SelCntA, 32'h0);
    expect_val("reset_commit", SelComA, 32'h0);
    sample();
    @(negedge clock);
    rst_n = 1'b1;

    // ALU and memory write-back
    @(negedge clock);
    wr(5'd3, 1'b0, 32'h0, 32'h0000_0011);
    expect_val("alu_commit", SelComA, 32'h1);
    expect_val("alu_cnt", SelCntA, 32'h1);
    rd_ports(5'd3, 5'd3);
    expect_val("alu_r3_a", SelRsA, 32'h11);
    expect_val("alu_r3_b", SelRtB, 32'h11);
    sample();
    wr(5'd4, 1'b1, 32'hCAFE_F00D, 32'h5555_5555);
    rd_ports(5'd3, 5'd4);
    expect_val("mem_r4", SelRtA, 32'hCAFE_F00D);
    expect_val("mem_r3_kept", SelRsA, 32'h11);
    expect_val("mem_cnt", SelCntA, 32'h2);
    sample();

    // Bypass vs no-bypass, sampled before the edge
    ifa.rs_addr = 5'd7;
    ifa.rt_addr = 5'd7;
    drive(1'b1, 5'd7, 1'b0, 32'h0, 32'h0000_1234);
    #1;
    expect_val("byp_rs", SelRsA, 32'h1234);
    expect_val("byp_rt", SelRtA, 32'h1234);
    expect_val("nobyp_rs_old", SelRsB, 32'h0);
    expect_val("nobyp_rt_old", SelRtB, 32'h0);
    sample();
    @(posedge clock);
    #1;
    rd_ports(5'd7, 5'd7);
    expect_val("nobyp_rs_new", SelRsB, 32'h1234);
    expect_val("byp_cnt", SelCntA, 32'h3);
    sample();

    // Writes to r0 are dropped
    ifa.rs_addr = 5'd0;
    drive(1'b1, 5'd0, 1'b0, 32'h0, 32'hFFFF_FFFF);
    #1;
    expect_val("r0_same_cycle", SelRsA, 32'h0);
    expect_val("r0_wbdata", SelWbA, 32'hFFFF_FFFF);
    sample();
    @(posedge clock);
    #1;
    rd_ports(5'd0, 5'd0);
    expect_val("r0_read", SelRtA, 32'h0);
    expect_val("r0_cnt", SelCntA, 32'h3);
    expect_val("r0_commit", SelComA, 32'h0);
    sample();

    // Disabled write and X destination with write disabled
    wr(5'd9, 1'b0, 32'h0, 32'h0000_0055);
    drive(1'b0, 5'd9, 1'b0, 32'h0, 32'h0000_AAAA);
    ifa.rs_addr = 5'd9;
    #1;
    expect_val("dis_wbdata", SelWbA, 32'h0000_AAAA);
    expect_val("dis_byp", SelRsA, 32'h55);
    sample();
    @(posedge clock);
    #1;
    expect_val("dis_r9", SelRsA, 32'h55);
    expect_val("dis_cnt", SelCntA, 32'h4);
    expect_val("dis_commit", SelComA, 32'h0);
    sample();
    drive(1'b0, 5'bx, 1'b1, 32'h1, 32'h2);
    @(posedge clock);
    #1;
    rd_ports(5'd9, 5'd3);
    expect_val("xrd_r9", SelRsA, 32'h55);
    expect_val("xrd_r3", SelRtA, 32'h11);
    expect_val("xrd_cnt", SelCntA, 32'h4);
    sample();

    // Mid-cycle asynchronous reset, then held through a clock edge
    wr(5'd5, 1'b0, 32'h0, 32'hDEAD_BEEF);
    rd_ports(5'd5, 5'd5);
    expect_val("pre_rst_r5", SelRsA, 32'hDEAD_BEEF);
    expect_val("pre_rst_commit", SelComA, 32'h1);
    sample();
    rst_n = 1'b0;
    #1;
    expect_val("rst_r5", SelRsA, 32'h0);
    expect_val("rst_cnt", SelCntA, 32'h0);
    expect_val("rst_commit", SelComA, 32'h0);
    sample();
    ifa.rs_addr = 5'd6;
    wr(5'd6, 1'b0, 32'h0, 32'h0000_0066);
    expect_val("rst_hold_r6", SelRsA, 32'h0);
    expect_val("rst_hold_cnt", SelCntA, 32'h0);
    expect_val("rst_hold_commit", SelComA, 32'h0);
    sample();
    rd_ports(5'd6, 5'd3);
    @(negedge clock);
    rst_n = 1'b1;
    #1;
    expect_val("post_rst_r6", SelRsA, 32'h0);
    expect_val("post_rst_r3", SelRtA, 32'h0);
    expect_val("post_rst_cnt_b", SelCntB, 32'h0);
    sample();

    // Counter wrap on the 4-bit build, then back-to-back writes to r2
    @(negedge clock);
    for (int i = 1; i <= 17; i++) begin
      wr(5'((i % 31) + 1), 1'b0, 32'h0, 32'(i));
    end
    ifa.RegWritereg = 1'b0;
    expect_val("wrap_cnt_b", SelCntB, 32'h1);
    expect_val("wrap_cnt_a", SelCntA, 32'd17);
    sample();
    wr(5'd2, 1'b0, 32'h0, 32'd1);
    wr(5'd2, 1'b0, 32'h0, 32'd2);
    wr(5'd2, 1'b0, 32'h0, 32'd3);
    rd_ports(5'd2, 5'd2);
    expect_val("b2b_r2_a", SelRsA, 32'd3);
    expect_val("b2b_r2_b", SelRtB, 32'd3);
    expect_val("b2b_cnt_b", SelCntB, 32'h4);
    expect_val("b2b_commit_b", SelComB, 32'h1);
    sample();
    @(posedge clock);
    #1;
    expect_val("idle_commit_a", SelComA, 32'h0);
    sample();

    #2;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
